pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the LEGv8 core. It sits directly downstream of the branch-source logic: it consumes the 2-bit `branch` select and holds the architectural PC. It computes the sequential, PC-relative and register-indirect next-PC values and runs a request/ready handshake with instruction memory. Fetched instructions are handed to decode/execute one at a time, with a valid/advance handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: width of the PC and all address ports.
- `RESET_PC`, 0: PC loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  reset. Asynchronous, active-low; asserting it (low) clears state immediately.
- `branch`  in  2  next-PC select from the branch source.
  - 2'b00 `NOOP`: sequential.
  - 2'b01 `PCBRANCH`: PC-relative.
  - 2'b10 `PCALUOUT`: register-indirect.
  - 2'b11: reserved, treated as sequential.
- `branch_offset`  in  ADDR_WIDTH  sign-extended word offset from the immediate unit.
- `alu_out`  in  ADDR_WIDTH  register target for BR.
- `advance`  in  1  execute accepts the held instruction; `branch` is valid this cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_WIDTH  fetch address.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction.
- `instr_valid`  out  1  `instr` / `instr_pc` are valid.
- `instr_pc`  out  ADDR_WIDTH  address of the held instruction.
- `pc_plus4`  out  ADDR_WIDTH  `instr_pc + 4`; this is the BL link value.
- `align_fault`  out  1  misaligned indirect target detected. Tied 0 unless the feature below is enabled.

## Operation
- State register encoding: IDLE, REQ, HOLD, FAULT.
- IDLE:
  - Entered on reset.
  - Always moves to REQ on the next edge.
- REQ:
  - `imem_req`=1 and `imem_addr`=pc.
  - On an edge where `imem_ready`=1:
    - `instr` <= `imem_rdata`
    - `instr_pc` <= pc
    - go to HOLD.
  - Otherwise stay in REQ; `imem_addr` is held stable.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - On an edge where `advance`=1, pc is loaded with the next-PC value selected by `branch`:
    - sequential: `instr_pc + 4`
    - PC-relative: `instr_pc + (branch_offset << 2)`
    - register-indirect: `alu_out`
  - Then go to REQ.
  - With `advance`=0, stay in HOLD and keep all outputs stable.
- FAULT: described under Configuration.
- Arithmetic:
  - All sums are modulo 2^ADDR_WIDTH; wrap-around is silent.
  - The top two bits of `branch_offset` are discarded by the shift.
- Ignored inputs:
  - `advance` is ignored outside HOLD.
  - `imem_ready` is ignored outside REQ.
  - `branch`, `branch_offset` and `alu_out` are sampled only on the HOLD+`advance` edge.
- Reset values (while `reset`=0):
  - state = IDLE, pc = `RESET_PC`, `instr_pc` = `RESET_PC`.
  - `instr` = 0, `instr_valid` = 0, `imem_req` = 0, `align_fault` = 0.
  - `imem_addr` = `RESET_PC`, `pc_plus4` = `RESET_PC + 4`.
- Reset mid-operation:
  - Reset asserted in REQ drops `imem_req` asynchronously; the outstanding request is abandoned.
  - A late `imem_ready` after reset is ignored (state is IDLE).

## Timing
- First fetch:
  - Cycle 0 is the first edge with `reset` high; state goes to REQ.
  - `imem_req` is high from cycle 1 with `imem_addr`=`RESET_PC`.
- Fetch latency:
  - `imem_ready` sampled high at edge N gives `instr_valid`=1 after edge N.
  - Zero-wait memory gives a throughput of 1 instruction per 2 cycles (REQ, HOLD).
- Redirect:
  - `advance` at edge M puts `imem_addr` at the new PC after edge M.
  - No wrong-path fetch is ever issued; the block has no speculation.
- `pc_plus4` is combinational from `instr_pc`.
- All other outputs are registered or decoded from state only.

## Configuration
- Macro: `PC_ALIGN_CHECK_EN`.
- Defined:
  - On the HOLD+`advance` edge with `branch`=2'b10 and `alu_out[1:0]`!=0, enter FAULT instead of REQ.
  - `align_fault`=1, `imem_req`=0, `instr_valid`=0.
  - pc keeps its old value.
  - FAULT is left only by reset.
- Undefined:
  - `alu_out[1:0]` is forced to 0 before loading pc.
  - FAULT is unreachable and `align_fault` is constant 0.

## Test plan
- Reset release with 0 wait states and `branch`=00 on every advance -> `imem_addr` sequence 0, 4, 8, 12; `pc_plus4`=`instr_pc`+4 each time.
- `imem_ready` held low 3 cycles in REQ -> `imem_addr` stable and `instr_valid`=0 throughout. Ready on the 4th cycle -> `instr` = `imem_rdata`.
- `instr_pc`=0x100, `branch`=01, `branch_offset`=-2 (all ones…FE) -> next `imem_addr`=0xF8. With `instr_pc`=0xFFFF_FFFF_FFFF_FFFC, `branch`=00 -> wraps to 0.
- `branch`=10, `alu_out`=0x2002:
  - Macro undefined -> `imem_addr`=0x2000.
  - Macro defined -> `align_fault`=1, `imem_req`=0, remains until reset.
- `advance`=0 held 5 cycles in HOLD -> outputs frozen and no request. `advance` pulsed during REQ -> ignored.
- Assert `reset` low asynchronously mid-REQ -> `imem_req`=0 before the next edge; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// LEGv8 program-counter and instruction-fetch stage: next-PC selection plus a
// req/ready fetch handshake. Optional misaligned-BR trap under PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter int unsigned                ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            branch,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic [ADDR_WIDTH-1:0] alu_out,
  input  logic                  advance,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  align_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    HOLD  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    NOOP     = 2'b00,
    PCBRANCH = 2'b01,
    PCALUOUT = 2'b10,
    RESERVED = 2'b11
  } branch_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(4);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic [ADDR_WIDTH-1:0]   seq_pc;
  logic [ADDR_WIDTH-1:0]   rel_pc;
  logic [ADDR_WIDTH-1:0]   ind_pc;
  logic                    ind_misaligned;
  branch_t                 branch_sel;

  assign branch_sel = branch_t'(branch);
  assign seq_pc     = instr_pc + WORD_BYTES;
  // Shift discards the top two offset bits; sum wraps silently.
  assign rel_pc     = instr_pc + (branch_offset << 2);

`ifdef PC_ALIGN_CHECK_EN
  assign ind_pc         = alu_out;
  assign ind_misaligned = (alu_out[1:0] != 2'b00);
`else
  assign ind_pc         = alu_out & ~ADDR_WIDTH'(3);
  assign ind_misaligned = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_ready) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          state_next = REQ;
          unique case (branch_sel)
            PCBRANCH: pc_next = rel_pc;
            PCALUOUT: begin
              if (ind_misaligned) begin
                state_next = FAULT;
              end else begin
                pc_next = ind_pc;
              end
            end
            default:  pc_next = seq_pc;
          endcase
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      instr_pc <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == REQ && imem_ready) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign pc_plus4    = instr_pc + WORD_BYTES;

`ifdef PC_ALIGN_CHECK_EN
  assign align_fault = (state == FAULT);
`else
  assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (default build): directed cases plus a
// randomized instruction stream checked against an architectural PC model.
module tb_pc_fetch_unit;

  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    branch;
  logic [AW-1:0] branch_offset;
  logic [AW-1:0] alu_out;
  logic          advance;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic [31:0]   instr;
  logic          instr_valid;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc_plus4;
  logic          align_fault;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Architectural model state: next fetch address and the held instruction.
  logic [AW-1:0] model_pc;
  logic [AW-1:0] held_pc;
  logic [31:0]   held_instr;

  pc_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .branch(branch), .branch_offset(branch_offset),
    .alu_out(alu_out), .advance(advance), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .pc_plus4(pc_plus4), .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered at a negedge with the DUT in REQ; leaves at a negedge in HOLD.
  task automatic do_fetch(input int unsigned waits, input logic [31:0] word);
    for (int unsigned i = 0; i < waits; i++) begin
      imem_ready    = 1'b0;
      imem_rdata    = $urandom;
      advance       = 1'($urandom_range(0, 1));
      branch        = 2'($urandom_range(0, 3));
      alu_out       = {$urandom, $urandom};
      check("req_wait", {62'd0, imem_req, instr_valid}, 64'h2);
      check("addr_wait", imem_addr, model_pc);
      @(negedge clk);
    end
    check("req_ready", {63'd0, imem_req}, 64'h1);
    check("addr_ready", imem_addr, model_pc);
    imem_ready = 1'b1;
    imem_rdata = word;
    advance    = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem_ready = 1'b0;
    advance    = 1'b0;
    held_pc    = model_pc;
    held_instr = word;
    check("valid_hold", {62'd0, instr_valid, imem_req}, 64'h2);
    check("instr", instr, held_instr);
    check("instr_pc", instr_pc, held_pc);
    check("pc_plus4", pc_plus4, held_pc + 64'd4);
    check("align_fault", align_fault, 64'd0);
  endtask

  // Entered at a negedge in HOLD; leaves at a negedge in REQ at the new PC.
  task automatic do_advance(input int unsigned stall, input logic [1:0] br,
                            input logic [AW-1:0] off, input logic [AW-1:0] tgt);
    for (int unsigned i = 0; i < stall; i++) begin
      advance       = 1'b0;
      branch        = 2'($urandom_range(0, 3));
      branch_offset = {$urandom, $urandom};
      imem_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("frozen_ctl", {62'd0, instr_valid, imem_req}, 64'h2);
      check("frozen_instr", instr, held_instr);
      check("frozen_pc", instr_pc, held_pc);
      check("frozen_addr", imem_addr, model_pc);
    end
    imem_ready    = 1'b0;
    advance       = 1'b1;
    branch        = br;
    branch_offset = off;
    alu_out       = tgt;
    case (br)
      2'b01:   model_pc = held_pc + off * 4;
      2'b10:   model_pc = {tgt[AW-1:2], 2'b00};
      default: model_pc = held_pc + 4;
    endcase
    @(negedge clk);
    advance = 1'b0;
    check("redirect_req", {63'd0, imem_req}, 64'h1);
    check("redirect_addr", imem_addr, model_pc);
  endtask

  initial begin
    reset = 1'b0; branch = '0; branch_offset = '0; alu_out = '0;
    advance = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    model_pc = '0; held_pc = '0; held_instr = '0;
    #3;
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", instr, 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_instr_pc", instr_pc, 64'd0);
    check("rst_pc_plus4", pc_plus4, 64'd4);
    check("rst_fault", align_fault, 64'd0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("first_req", {63'd0, imem_req}, 64'h1);

    // Sequential stream at zero wait: 0, 4, 8, 12.
    for (int unsigned k = 0; k < 4; k++) begin
      check("seq_addr", imem_addr, 64'(k * 4));
      do_fetch(0, $urandom);
      do_advance(0, 2'b00, '0, '0);
    end

    do_fetch(3, 32'hDEAD_BEEF);
    do_advance(5, 2'b00, '0, '0);

    do_fetch(0, $urandom);
    do_advance(0, 2'b10, '0, 64'h100);
    check("indirect_100", imem_addr, 64'h100);
    do_fetch(1, $urandom);
    do_advance(0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, '0);
    check("rel_neg2", imem_addr, 64'hF8);
    do_fetch(0, $urandom);
    do_advance(0, 2'b10, '0, 64'h2002);
    check("indirect_mask", imem_addr, 64'h2000);
    do_fetch(0, $urandom);
    do_advance(0, 2'b10, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    do_fetch(0, $urandom);
    do_advance(0, 2'b00, '0, '0);
    check("seq_wrap", imem_addr, 64'h0);
    do_fetch(0, $urandom);
    do_advance(0, 2'b11, {$urandom, $urandom}, {$urandom, $urandom});

    for (int unsigned n = 0; n < 40; n++) begin
      logic [1:0]    br;
      logic [AW-1:0] off;
      br  = 2'($urandom_range(0, 3));
      off = (n % 3 == 0) ? {$urandom, $urandom} : AW'($signed($urandom_range(0, 64)) - 32);
      do_fetch($urandom_range(0, 3), $urandom);
      do_advance($urandom_range(0, 2), br, off, {$urandom, $urandom});
    end

    // Asynchronous reset while a request is outstanding, then a late ready.
    #2;
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    #1;
    check("arst_req", {63'd0, imem_req}, 64'd0);
    check("arst_addr", imem_addr, 64'd0);
    check("arst_valid", {63'd0, instr_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("arst_late_ready", instr, 64'd0);
    check("arst_req_hold", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    reset      = 1'b1;
    imem_ready = 1'b0;
    model_pc   = '0;
    @(negedge clk);
    check("restart_req", {63'd0, imem_req}, 64'h1);
    do_fetch(0, 32'hCAFE_F00D);
    check("restart_pc", instr_pc, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
